// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state codes and widths for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;
  localparam int CTRL_STATE_W = 2;
  localparam int MUL_CNT_W = 4;
  typedef enum logic [CTRL_STATE_W-1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DMISS = 2'd1,
    CTRL_MUL   = 2'd2,
    CTRL_IMISS = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_cnt.sv
// pipe_ctrl_cnt: loadable down-counter with hold and zero flag for multiply occupancy
module pipe_ctrl_cnt
  import pipeline_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  input  logic [MUL_CNT_W-1:0] init,
  output logic [MUL_CNT_W-1:0] cnt,
  output logic                 zero
);
  // load wins over decrement; counter holds when neither is asserted
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer owning all pipeline register enables
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hz_load_use,
  input  logic                    icache_miss,
  input  logic                    icache_ready,
  input  logic                    dcache_miss,
  input  logic                    dcache_ready,
  input  logic                    mul_start,
  input  logic                    branch_taken,
  output logic                    pc_we,
  output logic                    if_id_we,
  output logic                    id_ex_we,
  output logic                    ex_mem_we,
  output logic                    mem_wb_we,
  output logic                    if_id_flush,
  output logic                    id_ex_bubble,
  output logic                    ex_mem_bubble,
  output logic                    mem_wb_bubble,
  output logic                    icache_cancel,
  output logic [CTRL_STATE_W-1:0] ctrl_state
);
  localparam logic [MUL_CNT_W-1:0] MUL_INIT = MUL_CNT_W'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
  ctrl_state_t state, nxt;
  logic mul_ret, zero, dm, frz_d, mul_go, mul_hold, frz_m, br, lu, im_go, fetch_stall;
  logic [MUL_CNT_W-1:0] cnt;
  pipe_ctrl_cnt u_cnt (
    .clk(clk), .reset(reset), .load(mul_go), .dec(mul_hold),
    .init(MUL_INIT), .cnt(cnt), .zero(zero)
  );
  // a miss with ready in the same cycle is a hit
  assign dm          = dcache_miss && !dcache_ready;
  assign frz_d       = state == CTRL_DMISS ? !dcache_ready : dm;
  assign mul_go      = state == CTRL_RUN && !dm && mul_start && (MUL_LAT > 1);
  assign mul_hold    = state == CTRL_MUL && !dm && !zero;
  assign frz_m       = mul_go || mul_hold;
  assign br          = branch_taken && !frz_d && !frz_m;
  assign lu          = state == CTRL_RUN && !dm && !mul_go && hz_load_use;
  assign im_go       = state == CTRL_RUN && !dm && !mul_go && !hz_load_use && icache_miss;
  assign fetch_stall = im_go || (state == CTRL_IMISS && !dm && !icache_ready);
  assign ctrl_state  = state;
  // state register plus the flag remembering a multiply interrupted by a D-miss
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= CTRL_RUN;
      mul_ret <= 1'b0;
    end else begin
      state   <= nxt;
      mul_ret <= (state == CTRL_MUL && dm) ? 1'b1 : (state == CTRL_DMISS && dcache_ready) ? 1'b0 : mul_ret;
    end
  // next-state selection; a D-miss preempts every state except DMISS itself
  always_comb
    nxt = (state != CTRL_DMISS && dm) ? CTRL_DMISS :
          state == CTRL_RUN   ? (mul_go ? CTRL_MUL : (im_go && !br) ? CTRL_IMISS : CTRL_RUN) :
          state == CTRL_DMISS ? (dcache_ready ? (mul_ret ? CTRL_MUL : CTRL_RUN) : CTRL_DMISS) :
          state == CTRL_MUL   ? (zero ? CTRL_RUN : CTRL_MUL) :
          (icache_ready || br) ? CTRL_RUN : CTRL_IMISS;
  // enable/bubble decode; a redirecting branch overrides load-use and fetch stalls
  always_comb begin
    pc_we         = !frz_d && !frz_m && (br || (!lu && !fetch_stall));
    if_id_we      = !frz_d && !frz_m && (br || !lu);
    id_ex_we      = !frz_d && !frz_m;
    ex_mem_we     = !frz_d;
    mem_wb_we     = 1'b1;
    if_id_flush   = br || fetch_stall;
    id_ex_bubble  = br || lu;
    ex_mem_bubble = frz_m;
    mem_wb_bubble = frz_d;
    icache_cancel = br && (state == CTRL_IMISS || im_go);
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic hz_load_use = 0, icache_miss = 0, icache_ready = 0, dcache_miss = 0, dcache_ready = 0;
  logic mul_start = 0, branch_taken = 0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, icache_cancel;
  logic [1:0] ctrl_state;
  int checks = 0, errors = 0;
  localparam logic [6:0] NO = 7'b0000000, HZ = 7'b1000000, IM = 7'b0100000, IR = 7'b0010000;
  localparam logic [6:0] DM = 7'b0001000, DR = 7'b0000100, MS = 7'b0000010, BR = 7'b0000001;
  localparam logic [9:0] DEF  = 10'b11111_00000;
  localparam logic [9:0] LU   = 10'b00111_01000;
  localparam logic [9:0] MULF = 10'b00011_00100;
  localparam logic [9:0] DMF  = 10'b00001_00010;
  localparam logic [9:0] IMF  = 10'b01111_10000;
  localparam logic [9:0] BRF  = 10'b11111_11000;
  localparam logic [9:0] BRC  = 10'b11111_11001;

  pipeline_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .hz_load_use(hz_load_use), .icache_miss(icache_miss),
    .icache_ready(icache_ready), .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .mul_start(mul_start), .branch_taken(branch_taken), .pc_we(pc_we), .if_id_we(if_id_we),
    .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .icache_cancel(icache_cancel), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble,
            ex_mem_bubble, mem_wb_bubble, icache_cancel, ctrl_state};
  endfunction

  task automatic cyc(input logic [6:0] in, input string tag, input logic [9:0] pat, input logic [1:0] st);
    {hz_load_use, icache_miss, icache_ready, dcache_miss, dcache_ready, mul_start, branch_taken} = in;
    #1 check(tag, obs(), {pat, st});
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1 check("reset", obs(), {DEF, 2'd0});
    @(negedge clk);
    reset = 1'b0;
    cyc(NO, "idle", DEF, 2'd0);
    cyc(HZ, "lu", LU, 2'd0);
    cyc(NO, "lu_end", DEF, 2'd0);
    cyc(MS, "mul0", MULF, 2'd0);
    cyc(MS, "mul1", MULF, 2'd2);
    cyc(MS, "mul2", MULF, 2'd2);
    cyc(MS, "mul_rel", DEF, 2'd2);
    cyc(NO, "mul_done", DEF, 2'd0);
    cyc(MS, "md_mul0", MULF, 2'd0);
    cyc(MS | DM, "md_miss", DMF, 2'd2);
    for (int i = 0; i < 4; i++) cyc(MS | DM, "md_wait", DMF, 2'd1);
    cyc(MS | DR, "md_ready", DEF, 2'd1);
    cyc(MS, "md_mul1", MULF, 2'd2);
    cyc(MS, "md_mul2", MULF, 2'd2);
    cyc(MS, "md_rel", DEF, 2'd2);
    cyc(NO, "md_done", DEF, 2'd0);
    cyc(IM, "im_go", IMF, 2'd0);
    cyc(IM, "im_wait", IMF, 2'd3);
    cyc(BR, "im_br", BRC, 2'd3);
    cyc(NO, "im_br_done", DEF, 2'd0);
    cyc(IM, "im_go2", IMF, 2'd0);
    cyc(IR, "im_ready", DEF, 2'd3);
    cyc(NO, "im_done", DEF, 2'd0);
    cyc(DM | HZ | BR, "dhb", DMF, 2'd0);
    cyc(DM | BR, "dhb_wait", DMF, 2'd1);
    cyc(DR | BR, "dhb_ready", BRF, 2'd1);
    cyc(NO, "dhb_done", DEF, 2'd0);
    cyc(DM | DR, "d_hit", DEF, 2'd0);
    cyc(HZ | BR, "lu_br", BRF, 2'd0);
    cyc(DM, "rst_miss", DMF, 2'd0);
    cyc(DM, "rst_wait", DMF, 2'd1);
    {hz_load_use, icache_miss, icache_ready, dcache_miss, dcache_ready, mul_start, branch_taken} = NO;
    reset = 1'b1;
    #1 check("rst_async", obs(), {DEF, 2'd0});
    @(negedge clk);
    reset = 1'b0;
    cyc(NO, "rst_idle", DEF, 2'd0);
    cyc(MS, "rst_mul0", MULF, 2'd0);
    reset = 1'b1;
    mul_start = 1'b0;
    #1 check("rst_mul", obs(), {DEF, 2'd0});
    @(negedge clk);
    reset = 1'b0;
    cyc(NO, "rst_idle2", DEF, 2'd0);
    cyc(MS, "re_mul0", MULF, 2'd0);
    cyc(MS, "re_mul1", MULF, 2'd2);
    cyc(MS, "re_mul2", MULF, 2'd2);
    cyc(MS, "re_rel", DEF, 2'd2);
    cyc(NO, "re_done", DEF, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
